rcs_serial_subtractor: RTL and testbench

//   Multi-cycle ripple-borrow subtractor: computes a - b - bin over DATA_WIDTH bits,

---
 rtl/rcs_serial_subtractor.sv | 149 ++++++++++++++
 tb/tb_rcs_serial_subtractor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rcs_serial_subtractor.sv
// Multi-cycle ripple-borrow subtractor: diff = a - b - bin, resolved CHUNK_WIDTH bits per clock
// with the inter-chunk borrow held in a flop; valid/ready handshake on both sides.
module rcs_serial_subtractor #(
  parameter int DATA_WIDTH  = 10,
  parameter int CHUNK_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   diff
);

  localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((CHUNK_WIDTH < 1) || (DATA_WIDTH % CHUNK_WIDTH != 0)) begin : g_bad_chunk
      $error("rcs_serial_subtractor: DATA_WIDTH must be a positive multiple of CHUNK_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    borrow;
  logic [DATA_WIDTH-1:0]   a_r;
  logic [DATA_WIDTH-1:0]   b_r;
  logic [DATA_WIDTH-1:0]   res;
  logic                    bout_r;
  logic                    in_ready_r;
  logic                    out_valid_r;

  logic [CHUNK_WIDTH-1:0]  chunk_a;
  logic [CHUNK_WIDTH-1:0]  chunk_b;
  logic [CHUNK_WIDTH-1:0]  chunk_d;
  logic                    chunk_bout;
  logic [CHUNK_WIDTH:0]    chunk_out;
  logic [DATA_WIDTH-1:0]   res_next;
  logic                    last_chunk;

  // Bit-serial ripple borrow across one chunk; returns {borrow_out, difference bits}.
  function automatic logic [CHUNK_WIDTH:0] sub_chunk(
    input logic [CHUNK_WIDTH-1:0] x,
    input logic [CHUNK_WIDTH-1:0] y,
    input logic                   br_in
  );
    logic                   br;
    logic [CHUNK_WIDTH-1:0] d;
    br = br_in;
    d  = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      d[i] = x[i] ^ y[i] ^ br;
      br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
    end
    return {br, d};
  endfunction

  // Chunk select / result merge by counter compare keeps every slice index constant.
  always_comb begin
    chunk_a  = '0;
    chunk_b  = '0;
    res_next = res;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt == CNT_W'(k)) begin
        chunk_a = a_r[k*CHUNK_WIDTH +: CHUNK_WIDTH];
        chunk_b = b_r[k*CHUNK_WIDTH +: CHUNK_WIDTH];
      end
    end
    chunk_out  = sub_chunk(chunk_a, chunk_b, borrow);
    chunk_bout = chunk_out[CHUNK_WIDTH];
    chunk_d    = chunk_out[CHUNK_WIDTH-1:0];
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt == CNT_W'(k)) begin
        res_next[k*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_d;
      end
    end
  end

  assign last_chunk = (cnt == CNT_W'(NCHUNK - 1));

  // The borrow flop is seeded with bin on accept, so chunk 0 sees bin and later chunks the carried borrow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      borrow      <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      res         <= '0;
      bout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r        <= a;
            b_r        <= b;
            borrow     <= bin;
            cnt        <= '0;
            state      <= BUSY;
            in_ready_r <= 1'b0;
          end
        end
        BUSY: begin
          res    <= res_next;
          borrow <= chunk_bout;
          if (last_chunk) begin
            cnt         <= '0;
            bout_r      <= chunk_bout;
            state       <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = {bout_r, res};

endmodule

// File: tb/tb_rcs_serial_subtractor.sv
// Directed and table-driven bench for rcs_serial_subtractor (DATA_WIDTH=10, CHUNK_WIDTH=2).
module tb_rcs_serial_subtractor;

  localparam int DW  = 10;
  localparam int CW  = 2;
  localparam int NCH = DW / CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          bin;
  logic          out_valid;
  logic          out_ready;
  logic [DW:0]   diff;

  int nchk  = 0;
  int nfail = 0;

  rcs_serial_subtractor #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          bin;
    logic [DW:0]   exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Full transaction with latency and in_ready checks; starts and ends at a negedge.
  task automatic do_op(input string name, input logic [DW-1:0] va, input logic [DW-1:0] vb,
                       input logic vbin, input logic [DW:0] exp);
    int  cycles;
    logic rdy_seen;
    wait_ready(name);
    a = va; b = vb; bin = vbin; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = '1; b = '1; bin = 1'b1;
    cycles = 0;
    rdy_seen = 1'b0;
    while (!out_valid && cycles < 20) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      cycles++;
    end
    check({name, "_latency"}, 32'(cycles), 32'(NCH));
    check({name, "_busy_in_ready"}, 32'(rdy_seen), 32'd0);
    check({name, "_diff"}, 32'(diff), 32'(exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_out_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  // Randomly gapped transaction against the arithmetic model a - b - bin.
  task automatic rand_op(input int idx);
    int          cycles;
    logic [DW:0] exp;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    wait_ready("rnd");
    a = DW'($urandom); b = DW'($urandom); bin = 1'($urandom);
    exp = {1'b0, a} - {1'b0, b} - (DW+1)'(bin);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'($urandom);
    a = DW'($urandom); b = DW'($urandom);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      out_ready = 1'($urandom);
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    if (diff !== exp || cycles != NCH)
      $display("op %0d: latency %0d", idx, cycles);
    check("rnd_diff", 32'(diff), 32'(exp));
    out_ready = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("rnd_hold", 32'(diff), 32'(exp));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rnd_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int cycles;

    vecs[0] = '{a: 10'd700,  b: 10'd123,  bin: 1'b0, exp: 11'd577};
    vecs[1] = '{a: 10'd5,    b: 10'd9,    bin: 1'b0, exp: 11'h7FC};
    vecs[2] = '{a: 10'd0,    b: 10'd0,    bin: 1'b1, exp: 11'h7FF};
    vecs[3] = '{a: 10'h200,  b: 10'd1,    bin: 1'b0, exp: 11'h1FF};
    vecs[4] = '{a: 10'd1023, b: 10'd1023, bin: 1'b0, exp: 11'd0};
    vecs[5] = '{a: 10'd1023, b: 10'd0,    bin: 1'b1, exp: 11'h3FE};
    vecs[6] = '{a: 10'd0,    b: 10'd1023, bin: 1'b0, exp: 11'h401};
    vecs[7] = '{a: 10'h200,  b: 10'h200,  bin: 1'b1, exp: 11'h7FF};
    vecs[8] = '{a: 10'd1023, b: 10'd0,    bin: 1'b0, exp: 11'h3FF};
    vecs[9] = '{a: 10'h155,  b: 10'h2AA,  bin: 1'b0, exp: 11'h6AB};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_diff", 32'(diff), 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp);
    end

    // Backpressure: result held while downstream stalls, new operands ignored.
    do_op("bp_warm", 10'd1, 10'd1, 1'b0, 11'd0);
    a = 10'd100; b = 10'd30; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 10'd1; b = 10'd2; bin = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check("bp_latency", 32'(cycles), 32'(NCH));
    for (int i = 0; i < 4; i++) begin
      check("bp_diff_hold", 32'(diff), 32'd70);
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_accept", 32'(in_ready), 32'd0);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check("bp_next_latency", 32'(cycles), 32'(NCH));
    check("bp_next_diff", 32'(diff), 32'h7FF);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during the third BUSY cycle discards the operation.
    wait_ready("rst_mid");
    a = 10'd700; b = 10'd123; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    cycles = 0;
    repeat (NCH + 2) begin
      @(negedge clk);
      if (out_valid) cycles++;
    end
    check("rst_mid_no_pulse", 32'(cycles), 32'd0);
    do_op("rst_mid_next", 10'd3, 10'd1, 1'b0, 11'd2);

    for (int i = 0; i < 300; i++) rand_op(i);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
